ahb3lite_interconnect_master_port: RTL



---
 rtl/ahb3lite_pkg.sv | 35 +++
 rtl/ahb3lite_interconnect_master_port_if.sv | 74 +++++++
 rtl/ahb3lite_interconnect_addr_decoder.sv | 29 ++
 rtl/ahb3lite_interconnect_master_port.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite bus encodings shared by the interconnect master port and its decoder.
package ahb3lite_pkg;

  // Transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Responses
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Burst types
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Transfer sizes
  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  // A transfer that actually moves data (NONSEQ or SEQ)
  function automatic logic trans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb3lite_interconnect_master_port_if.sv
// Bundle of the master-side AHB bus and the fan-out towards every slave port of the switch.
interface ahb3lite_interconnect_master_port_if #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32,
  parameter int unsigned SLAVES     = 8
);

  // Master side
  logic [2:0]            mst_priority;
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  // Decode map
  logic [HADDR_SIZE-1:0] slvHADDRbase [SLAVES];
  logic [HADDR_SIZE-1:0] slvHADDRmask [SLAVES];

  // Slave-port side
  logic [SLAVES-1:0]     slvHSEL;
  logic [HADDR_SIZE-1:0] slvHADDR;
  logic [HDATA_SIZE-1:0] slvHWDATA;
  logic                  slvHWRITE;
  logic [2:0]            slvHSIZE;
  logic [2:0]            slvHBURST;
  logic [3:0]            slvHPROT;
  logic [1:0]            slvHTRANS;
  logic                  slvHMASTLOCK;
  logic [1:0]            slvHTRANS4sw;
  logic                  slvHMASTLOCK4sw;
  logic                  slvHREADY;
  logic [2:0]            slv_priority;
  logic [HDATA_SIZE-1:0] slvHRDATA [SLAVES];
  logic [SLAVES-1:0]     slvHREADYOUT;
  logic [SLAVES-1:0]     slvHRESP;
  logic [SLAVES-1:0]     can_switch;
  logic [SLAVES-1:0]     granted;

  // View of the master port itself (the AHB slave that the master talks to)
  modport slave (
    input  mst_priority, HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
    input  HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP,
    input  slvHADDRbase, slvHADDRmask,
    output slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST, slvHPROT,
    output slvHTRANS, slvHMASTLOCK, slvHTRANS4sw, slvHMASTLOCK4sw, slvHREADY, slv_priority,
    input  slvHRDATA, slvHREADYOUT, slvHRESP,
    output can_switch,
    input  granted
  );

  // View of the surrounding system: the AHB master plus the slave ports and their arbiters
  modport master (
    output mst_priority, HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
    output HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP,
    output slvHADDRbase, slvHADDRmask,
    input  slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST, slvHPROT,
    input  slvHTRANS, slvHMASTLOCK, slvHTRANS4sw, slvHMASTLOCK4sw, slvHREADY, slv_priority,
    output slvHRDATA, slvHREADYOUT, slvHRESP,
    input  can_switch,
    output granted
  );

endinterface

// File: rtl/ahb3lite_interconnect_addr_decoder.sv
// Combinational base/mask address decoder; lowest matching slave index wins.
module ahb3lite_interconnect_addr_decoder #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned SLAVES     = 8
) (
  input  logic                  sel,
  input  logic [HADDR_SIZE-1:0] addr,
  input  logic [HADDR_SIZE-1:0] base [SLAVES],
  input  logic [HADDR_SIZE-1:0] mask [SLAVES],
  output logic [SLAVES-1:0]     hit,
  output logic                  no_hit
);

  logic found;

  // Priority scan from slave 0 upwards so overlapping regions resolve deterministically
  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int s = 0; s < SLAVES; s++) begin
      if (sel && !found && ((addr & mask[s]) == (base[s] & mask[s]))) begin
        hit[s] = 1'b1;
        found  = 1'b1;
      end
    end
    no_hit = sel && !found;
  end

endmodule

// File: rtl/ahb3lite_interconnect_master_port.sv
// Multi-layer switch master port: decodes, holds ungranted address phases, routes the data
// phase back from the owning slave port and tells the slave-port arbiters when they may switch.
module ahb3lite_interconnect_master_port
  import ahb3lite_pkg::*;
#(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32,
  parameter int unsigned SLAVES     = 8
) (
  input logic                                HCLK,
  input logic                                HRESET,
  ahb3lite_interconnect_master_port_if.slave bus
);

  // Error response sequencer states
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StErr1 = 2'd1;
  localparam logic [1:0] StErr2 = 2'd2;

  // Hold register for an address phase whose slave port has not granted us yet
  logic                  pending;
  logic [SLAVES-1:0]     pend_slv;
  logic [HADDR_SIZE-1:0] hold_addr;
  logic                  hold_write;
  logic [2:0]            hold_size;
  logic [2:0]            hold_burst;
  logic [3:0]            hold_prot;
  logic [1:0]            hold_trans;
  logic                  hold_lock;

  // Data-phase owner and the slave of the last accepted active transfer
  logic [SLAVES-1:0]     data_slv, data_slv_d;
  logic [SLAVES-1:0]     last_slv, last_slv_d;
  logic [1:0]            err_state, err_state_d;

  // Address phase as seen by the slave ports (live bus or hold register)
  logic                  cur_sel;
  logic [HADDR_SIZE-1:0] cur_addr;
  logic [SLAVES-1:0]     hit;
  logic                  no_hit;

  logic                  live_active;
  logic                  granted_hit;
  logic                  pend_granted;
  logic                  load;
  logic                  map_err;
  logic                  slv_ready;
  logic [SLAVES-1:0]     accept_slv;
  logic [SLAVES-1:0]     can_sw;

  logic [HDATA_SIZE-1:0] sel_hrdata;
  logic                  sel_hreadyout;
  logic                  sel_hresp;
  logic                  data_any;

  assign cur_sel  = pending | bus.HSEL;
  assign cur_addr = pending ? hold_addr : bus.HADDR;

  ahb3lite_interconnect_addr_decoder #(
    .HADDR_SIZE (HADDR_SIZE),
    .SLAVES     (SLAVES)
  ) u_addr_decoder (
    .sel    (cur_sel),
    .addr   (cur_addr),
    .base   (bus.slvHADDRbase),
    .mask   (bus.slvHADDRmask),
    .hit    (hit),
    .no_hit (no_hit)
  );

  assign live_active  = trans_active(bus.HTRANS);
  assign granted_hit  = |(hit & bus.granted);
  assign pend_granted = |(pend_slv & bus.granted);

  // A mapped active transfer to a slave port that is not granting us must be parked
  assign load    = !pending && bus.HREADY && live_active && (|hit) && !granted_hit;
  assign map_err = !pending && bus.HREADY && bus.HSEL && live_active && no_hit;

  // Select the response of the data-phase owner (one-hot, so OR-ing is a mux)
  always_comb begin
    sel_hrdata    = '0;
    sel_hreadyout = 1'b0;
    sel_hresp     = 1'b0;
    for (int s = 0; s < SLAVES; s++) begin
      if (data_slv[s]) begin
        sel_hrdata    = sel_hrdata | bus.slvHRDATA[s];
        sel_hreadyout = sel_hreadyout | bus.slvHREADYOUT[s];
        sel_hresp     = sel_hresp | bus.slvHRESP[s];
      end
    end
  end

  assign data_any = |data_slv;

  // While holding, the slave port only sees HREADY once it grants us, so it accepts exactly then
  assign slv_ready = pending ? pend_granted : (data_any ? sel_hreadyout : 1'b1);

  // Slave port whose address phase completes on the coming edge, if any
  always_comb begin
    accept_slv = '0;
    if (pending) begin
      if (pend_granted) begin
        accept_slv = pend_slv;
      end
    end else if (bus.HREADY && live_active && granted_hit) begin
      accept_slv = hit;
    end
  end

  // Data-phase owner follows whichever address phase the slave ports just accepted
  always_comb begin
    data_slv_d = data_slv;
    if (slv_ready) begin
      data_slv_d = accept_slv;
    end
  end

  // BUSY keeps the burst's slave; any other completed address phase replaces it
  always_comb begin
    last_slv_d = last_slv;
    if (slv_ready && (pending || (bus.HREADY && bus.HTRANS != HTRANS_BUSY))) begin
      last_slv_d = accept_slv;
    end
  end

  // Two-cycle ERROR response for transfers that decode to no slave port
  always_comb begin
    err_state_d = err_state;
    unique case (err_state)
      StIdle:  if (map_err) err_state_d = StErr1;
      StErr1:  err_state_d = StErr2;
      StErr2:  err_state_d = StIdle;
      default: err_state_d = StIdle;
    endcase
  end

  // Control state: pending flag, data-phase owner, burst tracking and error sequencer
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pending   <= 1'b0;
      pend_slv  <= '0;
      data_slv  <= '0;
      last_slv  <= '0;
      err_state <= StIdle;
    end else begin
      data_slv  <= data_slv_d;
      last_slv  <= last_slv_d;
      err_state <= err_state_d;
      if (pending) begin
        if (pend_granted) begin
          pending  <= 1'b0;
          pend_slv <= '0;
        end
      end else if (load) begin
        pending  <= 1'b1;
        pend_slv <= hit;
      end
    end
  end

  // Capture the parked address phase; contents are don't-care unless pending is set
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_addr  <= '0;
      hold_write <= 1'b0;
      hold_size  <= HSIZE_BYTE;
      hold_burst <= HBURST_SINGLE;
      hold_prot  <= '0;
      hold_trans <= HTRANS_IDLE;
      hold_lock  <= 1'b0;
    end else if (load) begin
      hold_addr  <= bus.HADDR;
      hold_write <= bus.HWRITE;
      hold_size  <= bus.HSIZE;
      hold_burst <= bus.HBURST;
      hold_prot  <= bus.HPROT;
      hold_trans <= bus.HTRANS;
      hold_lock  <= bus.HMASTLOCK;
    end
  end

  // Arbiters must not re-grant a slave that owns a parked transfer, a burst, or a lock
  always_comb begin
    can_sw = '1;
    for (int s = 0; s < SLAVES; s++) begin
      if ((pending && pend_slv[s]) ||
          (last_slv[s] && (bus.HTRANS == HTRANS_SEQ || bus.HTRANS == HTRANS_BUSY)) ||
          (bus.HMASTLOCK && last_slv[s])) begin
        can_sw[s] = 1'b0;
      end
    end
  end

  // Response to the master; pending and the error sequencer override the routed response
  always_comb begin
    bus.HRDATA    = sel_hrdata;
    bus.HREADYOUT = data_any ? sel_hreadyout : 1'b1;
    bus.HRESP     = data_any ? sel_hresp : HRESP_OKAY;
    if (pending) begin
      bus.HREADYOUT = 1'b0;
    end
    if (err_state == StErr1) begin
      bus.HREADYOUT = 1'b0;
      bus.HRESP     = HRESP_ERROR;
    end else if (err_state == StErr2) begin
      bus.HREADYOUT = 1'b1;
      bus.HRESP     = HRESP_ERROR;
    end
  end

  assign bus.slvHSEL         = hit;
  assign bus.slvHADDR        = cur_addr;
  assign bus.slvHWDATA       = bus.HWDATA;
  assign bus.slvHWRITE       = pending ? hold_write : bus.HWRITE;
  assign bus.slvHSIZE        = pending ? hold_size : bus.HSIZE;
  assign bus.slvHBURST       = pending ? hold_burst : bus.HBURST;
  assign bus.slvHPROT        = pending ? hold_prot : bus.HPROT;
  assign bus.slvHTRANS       = pending ? hold_trans : bus.HTRANS;
  assign bus.slvHMASTLOCK    = pending ? hold_lock : bus.HMASTLOCK;
  // A held SEQ starts afresh at an arbiter that has not yet served this master
  assign bus.slvHTRANS4sw    = pending ? HTRANS_NONSEQ : bus.HTRANS;
  assign bus.slvHMASTLOCK4sw = pending ? hold_lock : bus.HMASTLOCK;
  assign bus.slvHREADY       = slv_ready;
  assign bus.slv_priority    = bus.mst_priority;
  assign bus.can_switch      = can_sw;

endmodule
